// File: rtl/mdu_iter.sv
// mdu_iter - iterative multiply/divide unit for the EX stage.
//
// One shared datapath serves MULT, MULTU, DIV and DIVU. Each operation
// resolves one bit per clock over WIDTH cycles. Signed operands are
// processed as magnitudes, and the sign is applied in a final FIX cycle.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   start_i    request pulse; sampled only in IDLE
//   annul_i    abort the current operation (pipeline flush)
//   div_i      1 = divide, 0 = multiply; sampled with start_i
//   signed_i   1 = two's-complement operands; sampled with start_i
//   opdata1_i  multiplicand / dividend
//   opdata2_i  multiplier / divisor
//   busy_o     high while in RUN or FIX
//   ready_o    one-cycle completion strobe
//   divz_o     divisor was zero; valid while ready_o is high
//   result_o   {hi, lo}: the product, or {remainder, quotient};
//              held until the next accepted start
module mdu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 annul_i,
   input  logic                 div_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic                 divz_o,
   output logic [2*WIDTH-1:0]   result_o
);

   localparam int unsigned     CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic                 div_q;
   logic                 res_neg_q;
   logic                 rem_neg_q;
   // Holds the multiplicand (multiply) or the divisor (divide).
   logic [WIDTH-1:0]     opnd_q;
   // Holds the partial remainder for divide.
   logic [WIDTH-1:0]     rem_q;
   // Multiply: {partial product hi, multiplier shifting out}.
   // Divide:   low half = dividend shifting out / quotient shifting in.
   logic [2*WIDTH-1:0]   acc_q;
   logic                 divz_q;
   logic [2*WIDTH-1:0]   result_q;

   logic                 accept;
   logic                 divz_start;
   logic                 op1_neg, op2_neg;
   logic [WIDTH-1:0]     mag1, mag2;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_acc_d;
   logic [WIDTH:0]       div_trial;
   logic                 div_borrow;
   logic [WIDTH-1:0]     div_diff;
   logic [WIDTH-1:0]     rem_d;
   logic [2*WIDTH-1:0]   div_acc_d;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix;
   logic [WIDTH-1:0]     rem_fix;
   logic [2*WIDTH-1:0]   fix_result;

   assign accept     = (state_q == S_IDLE) && start_i && !annul_i;
   assign divz_start = div_i && (opdata2_i == '0);
   assign op1_neg    = signed_i & opdata1_i[WIDTH-1];
   assign op2_neg    = signed_i & opdata2_i[WIDTH-1];
   // The most-negative value maps onto itself. Read as unsigned, that is the
   // correct magnitude 2^(WIDTH-1).
   assign mag1       = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
   assign mag2       = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

   // Datapath step functions.
   always_comb begin
      // Shift-add multiply, LSB first. The carry out of the add lands in the
      // top bit, and the whole accumulator shifts right by one.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

      // Restoring divide, MSB first, with a (WIDTH+1)-bit trial remainder.
      // Once the subtract succeeds, the difference is below the divisor, so it
      // fits in WIDTH bits. The modulo-2^WIDTH subtract is therefore exact.
      div_trial  = {rem_q, acc_q[WIDTH-1]};
      div_borrow = div_trial < {1'b0, opnd_q};
      div_diff   = div_trial[WIDTH-1:0] - opnd_q;
      rem_d      = div_borrow ? div_trial[WIDTH-1:0] : div_diff;
      div_acc_d  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_borrow};

      // Sign correction.
      prod_fix   = res_neg_q ? (~acc_q + 1'b1) : acc_q;
      quot_fix   = res_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix    = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
      fix_result = div_q ? {rem_fix, quot_fix} : prod_fix;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      ready_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = divz_start ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy_o = 1'b1;
            if (annul_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            busy_o  = 1'b1;
            state_d = annul_i ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            ready_o = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         div_q     <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         opnd_q    <= '0;
         rem_q     <= '0;
         acc_q     <= '0;
         divz_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         if (accept) begin
            div_q     <= div_i;
            res_neg_q <= op1_neg ^ op2_neg;
            rem_neg_q <= op1_neg;
            cnt_q     <= '0;
            rem_q     <= '0;
            divz_q    <= divz_start;
            if (div_i) begin
               opnd_q <= mag2;
               acc_q  <= {{WIDTH{1'b0}}, mag1};
            end else begin
               opnd_q <= mag1;
               acc_q  <= {{WIDTH{1'b0}}, mag2};
            end
            // A zero divisor returns the raw dividend, with no sign fix.
            if (divz_start) begin
               result_q <= {opdata1_i, {WIDTH{1'b1}}};
            end
         end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (div_q) begin
               acc_q <= div_acc_d;
               rem_q <= rem_d;
            end else begin
               acc_q <= mul_acc_d;
            end
         end else if (state_q == S_FIX && !annul_i) begin
            result_q <= fix_result;
         end
      end
   end

   assign divz_o   = divz_q;
   assign result_o = result_q;

endmodule
